apb_uart_rx_fifo: RTL and testbench
===================================

Name: apb_uart_rx_fifo

Overview:
APB-mapped UART receiver, the parametrised successor to the single-buffer APB UART RX peripheral. It adds a configurable-depth receive FIFO, optional even/odd parity checking and sticky per-error flags cleared by software. It sits on the APB bus as a slave and samples one asynchronous serial line. Frames are 5–8 data bits, LSB first, 1 stop bit.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; must be a power of 2, range 2..64.
BP_W, 14, bit-period counter width in clocks.
RESET_BP, 10, bit period loaded at reset.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
serial_in  in  1  asynchronous serial line, idle high
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  APB write
paddr  in  3  APB register address
pwdata  in  8  APB write data
prdata  out  8  APB read data
pslverr  out  1  APB slave error, access phase only

Behaviour:
- Reset state: prdata=0, pslverr=0, FIFO empty, all error flags 0, bit_period=RESET_BP, data_size=8, parity=none, FSM=IDLE, synchroniser flops=1.
- APB: zero wait states (no pready). prdata and pslverr are combinational and nonzero only when psel&penable. Register updates, pops and flag clears occur on the clk edge that ends the access phase.
- Register map:
  - 0 STATUS RO: [0] not-empty, [1] full, [2] overrun, [3] framing, [4] parity; [7:5]=0.
  - 1 ERR_CLR WO: pwdata[2:0]=1 clears overrun/framing/parity respectively.
  - 2 BP_LO RW: bit_period[7:0].
  - 3 BP_HI RW: bit_period[BP_W-1:8].
  - 4 DATA_SIZE RW [3:0].
  - 5 PARITY RW [1:0]: 0 none, 1 even, 2 odd.
  - 6 RX_DATA RO, pops the FIFO.
  - 7 COUNT RO: FIFO occupancy.
- pslverr=1 and no state change when:
  - writing a RO register (0, 6, 7);
  - reading WO register 1;
  - writing DATA_SIZE outside 5..8;
  - writing PARITY=3.
- Reading RX_DATA while empty returns 0x00 with pslverr=0 and no pop.
- serial_in passes through a 2-flop synchroniser. Falling-edge detection uses the synchronised value.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: on a falling edge, latch bit_period, data_size and parity into working copies, clear the counter, go to START. Config writes mid-frame affect only the next frame.
  - START: sample at count = bit_period>>1. If low, go to DATA. If high (false start), return to IDLE with no flag set.
  - DATA: sample every bit_period clocks; shift LSB-first for data_size bits. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: sample one bit and compare with the even/odd parity of the data bits.
  - STOP: sample one bit, then return to IDLE on the same edge, ready for a back-to-back start.
- STOP outcome:
  - Stop=0: discard the word, set framing.
  - Stop=1 with parity mismatch: discard the word, set parity.
  - Otherwise push the word, right-justified with upper bits zero, on the cycle after the stop sample. STATUS[0] is visible on the following read.
- Push while full: word dropped, oldest entries kept, overrun set.
- Push and pop on the same edge while full: both succeed, no overrun, count unchanged.
- Error flags are sticky until ERR_CLR. If a set and a clear of the same flag coincide, the set wins.
- bit_period values below 4 are treated as 4.
- rst mid-frame: aborts the frame, empties the FIFO, restores all defaults.

Decomposition:
- Package uart_rx_pkg holds:
  - register address localparams;
  - parity_mode_t enum;
  - rx_state_t enum;
  - STATUS bit-index constants;
  - MIN_BIT_PERIOD=4.
- One sub-module, uart_rx_sync_fifo: a synchronous FIFO parametrised by width 8 and FIFO_DEPTH, with push, pop, full, empty and count outputs. It has no overwrite and allows simultaneous push/pop.

Test Plan:
- Defaults: send 0xA5 (8N1) at bp=10 → STATUS=0x01, COUNT=1. RX_DATA read returns 0xA5, then STATUS=0x00.
- Width/parity: DATA_SIZE=5, PARITY=even (1), bp=20. Send 0x13 with parity bit 1 → RX_DATA=0x13. Send 0x13 with parity bit 0 → no push, STATUS[4]=1. ERR_CLR 0x04 → STATUS[4]=0.
- Overrun: FIFO_DEPTH=8, send 9 back-to-back bytes 0x01..0x09 → COUNT=8, STATUS[1]=1, STATUS[2]=1. Eight reads return 0x01..0x08.
- Framing/false start: stop bit held low → no push, STATUS[3]=1. A 2-clock low glitch at bp=10 → FSM returns to IDLE with no flag and no push.
- APB errors: write to addr 0 → pslverr=1. Write DATA_SIZE=9 → pslverr=1, DATA_SIZE reads 8. Read addr 1 → pslverr=1. Read addr 6 while empty → 0x00 with pslverr=0.
- Mid-frame changes: write bp=40 during a frame → current byte still decodes at bp=10. Assert rst mid-frame → FIFO empty, BP_LO reads 10, DATA_SIZE reads 8, PARITY reads 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the APB UART receiver with FIFO.
// Register map, FSM/parity encodings and STATUS bit positions.
package uart_rx_pkg;

  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_ERR_CLR   = 3'd1;
  localparam logic [2:0] ADDR_BP_LO     = 3'd2;
  localparam logic [2:0] ADDR_BP_HI     = 3'd3;
  localparam logic [2:0] ADDR_DATA_SIZE = 3'd4;
  localparam logic [2:0] ADDR_PARITY    = 3'd5;
  localparam logic [2:0] ADDR_RX_DATA   = 3'd6;
  localparam logic [2:0] ADDR_COUNT     = 3'd7;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAMING   = 3;
  localparam int STAT_PARITY    = 4;

  localparam int MIN_BIT_PERIOD = 4;
  localparam logic [3:0] DEF_DATA_SIZE = 4'd8;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous FIFO, no overwrite; push and pop may share an edge.
// A push into a full FIFO only lands when a pop frees a slot that cycle.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_uart_rx_fifo.sv
// APB slave UART receiver: 5-8 data bits, optional parity, 1 stop,
// receive FIFO and sticky error flags cleared through ERR_CLR.
module apb_uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int BP_W       = 14,
  parameter int RESET_BP   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [2:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pslverr
);
  import uart_rx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      sync_q;
  logic            prev_q;
  logic            rx_s, fall;
  logic [BP_W-1:0] bp_q, eff_bp;
  logic [3:0]      ds_q;
  parity_mode_t    par_q;
  rx_state_t       state_q;
  logic [BP_W-1:0] bp_w_q, cnt_q;
  logic [3:0]      ds_w_q, bit_q;
  parity_mode_t    par_w_q;
  logic [7:0]      data_q, push_data_q;
  logic            par_err_q, push_q;
  logic            ovr_q, frm_q, perr_q;
  logic            bit_end, stop_samp, exp_par;
  logic            set_ovr, set_frm, set_perr;
  logic            acc, wr_acc, rd_acc, err, wr_ok, pop;
  logic [2:0]      clr;
  logic [15:0]     bp_ext, bp_wr;
  logic [7:0]      fifo_rdata;
  logic            full, empty;
  logic [CW-1:0]   count;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  assign eff_bp = (bp_q < BP_W'(MIN_BIT_PERIOD)) ? BP_W'(MIN_BIT_PERIOD) : bp_q;
  assign bit_end = (cnt_q == bp_w_q - BP_W'(1));
  assign exp_par = (par_w_q == PAR_ODD) ? ~^data_q : ^data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], serial_in};
      prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bp_w_q      <= BP_W'(RESET_BP);
      ds_w_q      <= DEF_DATA_SIZE;
      par_w_q     <= PAR_NONE;
      cnt_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      cnt_q  <= cnt_q + BP_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (fall) begin
            bp_w_q  <= eff_bp;
            ds_w_q  <= ds_q;
            par_w_q <= par_q;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q == (bp_w_q >> 1)) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= ST_DATA;
              bit_q     <= '0;
              data_q    <= '0;
              par_err_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            data_q[bit_q[2:0]] <= rx_s;
            bit_q <= bit_q + 4'd1;
            if (bit_q == ds_w_q - 4'd1)
              state_q <= (par_w_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            cnt_q     <= '0;
            par_err_q <= (rx_s != exp_par);
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            if (rx_s && !par_err_q) begin
              push_q      <= 1'b1;
              push_data_q <= data_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stop_samp = (state_q == ST_STOP) & bit_end;
  assign set_frm   = stop_samp & ~rx_s;
  assign set_perr  = stop_samp & rx_s & par_err_q;
  assign set_ovr   = push_q & full & ~pop;

  assign acc    = psel & penable;
  assign wr_acc = acc & pwrite;
  assign rd_acc = acc & ~pwrite;

  always_comb begin
    err = 1'b0;
    unique case (1'b1)
      wr_acc: begin
        unique case (paddr)
          ADDR_STATUS, ADDR_RX_DATA, ADDR_COUNT: err = 1'b1;
          ADDR_DATA_SIZE: err = !(pwdata inside {[8'd5:8'd8]});
          ADDR_PARITY:    err = (pwdata[1:0] == 2'd3);
          default:        err = 1'b0;
        endcase
      end
      rd_acc:  err = (paddr == ADDR_ERR_CLR);
      default: err = 1'b0;
    endcase
  end

  assign pslverr = err;
  assign wr_ok   = wr_acc & ~err;
  assign pop     = rd_acc & (paddr == ADDR_RX_DATA) & ~empty;
  assign clr     = (wr_ok && paddr == ADDR_ERR_CLR) ? pwdata[2:0] : 3'b000;
  assign bp_ext  = 16'(bp_q);

  always_comb begin
    bp_wr = bp_ext;
    if (paddr == ADDR_BP_LO) bp_wr[7:0] = pwdata;
    else bp_wr[15:8] = pwdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q   <= BP_W'(RESET_BP);
      ds_q   <= DEF_DATA_SIZE;
      par_q  <= PAR_NONE;
      ovr_q  <= 1'b0;
      frm_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (wr_ok && (paddr == ADDR_BP_LO || paddr == ADDR_BP_HI))
        bp_q <= bp_wr[BP_W-1:0];
      if (wr_ok && paddr == ADDR_DATA_SIZE) ds_q <= pwdata[3:0];
      if (wr_ok && paddr == ADDR_PARITY) par_q <= parity_mode_t'(pwdata[1:0]);
      // A set landing on the same edge as its clear wins.
      ovr_q  <= set_ovr  | (ovr_q  & ~clr[0]);
      frm_q  <= set_frm  | (frm_q  & ~clr[1]);
      perr_q <= set_perr | (perr_q & ~clr[2]);
    end
  end

  always_comb begin
    prdata = 8'h00;
    if (rd_acc) begin
      unique case (paddr)
        ADDR_STATUS: begin
          prdata[STAT_NOT_EMPTY] = ~empty;
          prdata[STAT_FULL]      = full;
          prdata[STAT_OVERRUN]   = ovr_q;
          prdata[STAT_FRAMING]   = frm_q;
          prdata[STAT_PARITY]    = perr_q;
        end
        ADDR_BP_LO:     prdata = bp_ext[7:0];
        ADDR_BP_HI:     prdata = bp_ext[15:8];
        ADDR_DATA_SIZE: prdata = {4'h0, ds_q};
        ADDR_PARITY:    prdata = {6'h00, par_q};
        ADDR_RX_DATA:   prdata = empty ? 8'h00 : fifo_rdata;
        ADDR_COUNT:     prdata = 8'(count);
        default:        prdata = 8'h00;
      endcase
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i (push_data_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_apb_uart_rx_fifo.sv
// Directed bench for apb_uart_rx_fifo: frames driven on serial_in,
// registers checked over APB against hand-computed values.
module tb_apb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [2:0] paddr = 3'd0;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_uart_rx_fifo #(
    .FIFO_DEPTH (8),
    .BP_W       (14),
    .RESET_BP   (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic w, input logic [2:0] a,
                     input logic [7:0] d, output logic [7:0] rd,
                     output logic er);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0;
    pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata;
    er = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    logic e;
    apb(1'b0, a, 8'h00, d, e);
    chk(tag, d, exp);
    chk({tag, "_err"}, {7'd0, e}, 8'h00);
  endtask

  task automatic wr_chk(input string tag, input logic [2:0] a,
                        input logic [7:0] d, input logic exp_err);
    logic [7:0] r;
    logic e;
    apb(1'b1, a, d, r, e);
    chk(tag, {7'd0, e}, {7'd0, exp_err});
  endtask

  task automatic send(input logic [7:0] d, input int n, input int bp,
                      input bit pe, input logic pb, input logic sb);
    @(negedge clk);
    serial_in = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      serial_in = d[i];
      repeat (bp) @(negedge clk);
    end
    if (pe) begin
      serial_in = pb;
      repeat (bp) @(negedge clk);
    end
    serial_in = sb;
    repeat (bp) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic e;

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_prdata", prdata, 8'h00);
    chk("rst_pslverr", {7'd0, pslverr}, 8'h00);
    rd_chk("rst_status", 3'd0, 8'h00);
    rd_chk("rst_bp_lo", 3'd2, 8'd10);
    rd_chk("rst_bp_hi", 3'd3, 8'h00);
    rd_chk("rst_dsize", 3'd4, 8'd8);
    rd_chk("rst_parity", 3'd5, 8'd0);
    rd_chk("rst_count", 3'd7, 8'd0);

    send(8'hA5, 8, 10, 0, 1'b0, 1'b1);
    idle(3);
    rd_chk("a5_status", 3'd0, 8'h01);
    rd_chk("a5_count", 3'd7, 8'd1);
    rd_chk("a5_data", 3'd6, 8'hA5);
    rd_chk("a5_status_after", 3'd0, 8'h00);

    wr_chk("w_dsize5", 3'd4, 8'd5, 1'b0);
    wr_chk("w_par_even", 3'd5, 8'd1, 1'b0);
    wr_chk("w_bp20", 3'd2, 8'd20, 1'b0);
    send(8'h13, 5, 20, 1, 1'b1, 1'b1);
    idle(3);
    rd_chk("par_ok_data", 3'd6, 8'h13);
    send(8'h13, 5, 20, 1, 1'b0, 1'b1);
    idle(3);
    rd_chk("par_bad_status", 3'd0, 8'h10);
    rd_chk("par_bad_count", 3'd7, 8'd0);
    wr_chk("w_clr_par", 3'd1, 8'h04, 1'b0);
    rd_chk("par_clr_status", 3'd0, 8'h00);
    wr_chk("w_dsize8", 3'd4, 8'd8, 1'b0);
    wr_chk("w_par_none", 3'd5, 8'd0, 1'b0);
    wr_chk("w_bp10", 3'd2, 8'd10, 1'b0);

    for (int i = 1; i <= 9; i++) send(8'(i), 8, 10, 0, 1'b0, 1'b1);
    idle(3);
    rd_chk("ovr_count", 3'd7, 8'd8);
    rd_chk("ovr_status", 3'd0, 8'h07);
    for (int i = 1; i <= 8; i++) rd_chk("ovr_data", 3'd6, 8'(i));
    rd_chk("ovr_status_empty", 3'd0, 8'h04);
    wr_chk("w_clr_all", 3'd1, 8'h07, 1'b0);

    send(8'h55, 8, 10, 0, 1'b0, 1'b0);
    idle(20);
    rd_chk("frm_status", 3'd0, 8'h08);
    wr_chk("w_clr_frm", 3'd1, 8'h02, 1'b0);
    rd_chk("frm_clr_status", 3'd0, 8'h00);

    @(negedge clk); serial_in = 1'b0;
    idle(2); serial_in = 1'b1;
    idle(20);
    rd_chk("glitch_status", 3'd0, 8'h00);
    rd_chk("glitch_count", 3'd7, 8'd0);
    send(8'hC3, 8, 10, 0, 1'b0, 1'b1);
    idle(3);
    rd_chk("post_glitch_data", 3'd6, 8'hC3);

    wr_chk("w_ro_status", 3'd0, 8'h00, 1'b1);
    wr_chk("w_dsize9", 3'd4, 8'd9, 1'b1);
    rd_chk("dsize_kept", 3'd4, 8'd8);
    wr_chk("w_par3", 3'd5, 8'd3, 1'b1);
    rd_chk("par_kept", 3'd5, 8'd0);
    apb(1'b0, 3'd1, 8'h00, d, e);
    chk("rd_wo_err", {7'd0, e}, 8'h01);
    rd_chk("rd_empty_data", 3'd6, 8'h00);

    fork
      send(8'h5A, 8, 10, 0, 1'b0, 1'b1);
      begin
        idle(30);
        apb(1'b1, 3'd2, 8'd40, d, e);
      end
    join
    idle(3);
    rd_chk("mid_bp_data", 3'd6, 8'h5A);
    rd_chk("mid_bp_lo", 3'd2, 8'd40);
    send(8'h3C, 8, 40, 0, 1'b0, 1'b1);
    idle(3);
    rd_chk("bp40_count", 3'd7, 8'd1);

    wr_chk("w_dsize7", 3'd4, 8'd7, 1'b0);
    wr_chk("w_par_odd", 3'd5, 8'd2, 1'b0);
    fork
      send(8'hFF, 8, 40, 0, 1'b0, 1'b1);
      begin
        idle(100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(20);
    rd_chk("rst_mid_count", 3'd7, 8'd0);
    rd_chk("rst_mid_status", 3'd0, 8'h00);
    rd_chk("rst_mid_bp_lo", 3'd2, 8'd10);
    rd_chk("rst_mid_dsize", 3'd4, 8'd8);
    rd_chk("rst_mid_parity", 3'd5, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
